// File: rtl/acc_pkg.sv
// Shared constants for the accumulator logic stage: opcodes and FSM state codes.
package acc_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_CLR  = 4'd1;
    localparam logic [3:0] OP_LOAD = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_ADD  = 4'd7;
    localparam logic [3:0] OP_SUB  = 4'd8;
    // Opcodes above this value are illegal.
    localparam logic [3:0] OP_LAST = OP_SUB;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

endpackage

// File: rtl/acc_logic_stage_if.sv
// Handshake and result bus of the accumulator stage; the sat field exists only
// when ACC_SAT_EN is defined.
interface acc_logic_stage_if #(
    parameter int WIDTH = 4
) ();

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] operand;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic             zero;
    logic             overflow;
    logic             error;
`ifdef ACC_SAT_EN
    logic             sat;
`endif

    modport master (
        output in_valid, opcode, operand, out_ready,
        input  in_ready, out_valid, acc, carry, zero, overflow, error
`ifdef ACC_SAT_EN
        , input sat
`endif
    );

    modport slave (
        input  in_valid, opcode, operand, out_ready,
        output in_ready, out_valid, acc, carry, zero, overflow, error
`ifdef ACC_SAT_EN
        , output sat
`endif
    );

endinterface

// File: rtl/acc_gates.sv
// Bitwise gate modules (AND/OR/XOR/NOT) that feed the accumulator stage.
module gate_and4 #(parameter int W = 4) (
    input  logic [W-1:0] inputA,
    input  logic [W-1:0] inputB,
    output logic [W-1:0] y
);
    assign y = inputA & inputB;
endmodule

module gate_or4 #(parameter int W = 4) (
    input  logic [W-1:0] inputA,
    input  logic [W-1:0] inputB,
    output logic [W-1:0] y
);
    assign y = inputA | inputB;
endmodule

module gate_xor4 #(parameter int W = 4) (
    input  logic [W-1:0] inputA,
    input  logic [W-1:0] inputB,
    output logic [W-1:0] y
);
    assign y = inputA ^ inputB;
endmodule

module gate_not4 #(parameter int W = 4) (
    input  logic [W-1:0] inputA,
    output logic [W-1:0] y
);
    assign y = ~inputA;
endmodule

// File: rtl/acc_logic_unit.sv
// Combinational next-accumulator and flag computation; ACC_SAT_EN enables
// clamping of ADD/SUB on carry/borrow.
module acc_logic_unit #(
    parameter int WIDTH = 4
) (
    input  logic [3:0]       opcode_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] operand_i,
    output logic [WIDTH-1:0] acc_o,
    output logic             carry_o,
    output logic             overflow_o,
`ifdef ACC_SAT_EN
    output logic             sat_o,
`endif
    output logic             illegal_o
);
    import acc_pkg::*;

    logic [WIDTH-1:0] and_w, or_w, xor_w, not_w;
    logic [WIDTH:0]   sum_w, dif_w;

    gate_and4 #(.W(WIDTH)) u_and (.inputA(acc_i), .inputB(operand_i), .y(and_w));
    gate_or4  #(.W(WIDTH)) u_or  (.inputA(acc_i), .inputB(operand_i), .y(or_w));
    gate_xor4 #(.W(WIDTH)) u_xor (.inputA(acc_i), .inputB(operand_i), .y(xor_w));
    gate_not4 #(.W(WIDTH)) u_not (.inputA(acc_i), .y(not_w));

    // Bit WIDTH of the extended difference is the unsigned borrow.
    assign sum_w     = {1'b0, acc_i} + {1'b0, operand_i};
    assign dif_w     = {1'b0, acc_i} - {1'b0, operand_i};
    assign illegal_o = (opcode_i > OP_LAST);

    function automatic logic sign_ovf(input logic a, input logic b, input logic r,
                                      input logic sub);
        return (sub ? (a != b) : (a == b)) && (r != a);
    endfunction

    always_comb begin
        acc_o      = acc_i;
        carry_o    = 1'b0;
        overflow_o = 1'b0;
`ifdef ACC_SAT_EN
        sat_o      = 1'b0;
`endif
        case (opcode_i)
            OP_CLR:  acc_o = '0;
            OP_LOAD: acc_o = operand_i;
            OP_AND:  acc_o = and_w;
            OP_OR:   acc_o = or_w;
            OP_XOR:  acc_o = xor_w;
            OP_NOT:  acc_o = not_w;
            OP_ADD: begin
                acc_o      = sum_w[WIDTH-1:0];
                carry_o    = sum_w[WIDTH];
                overflow_o = sign_ovf(acc_i[WIDTH-1], operand_i[WIDTH-1],
                                      sum_w[WIDTH-1], 1'b0);
`ifdef ACC_SAT_EN
                if (sum_w[WIDTH]) begin
                    acc_o = '1;
                    sat_o = 1'b1;
                end
`endif
            end
            OP_SUB: begin
                acc_o      = dif_w[WIDTH-1:0];
                carry_o    = dif_w[WIDTH];
                overflow_o = sign_ovf(acc_i[WIDTH-1], operand_i[WIDTH-1],
                                      dif_w[WIDTH-1], 1'b1);
`ifdef ACC_SAT_EN
                if (dif_w[WIDTH]) begin
                    acc_o = '0;
                    sat_o = 1'b1;
                end
`endif
            end
            default: acc_o = acc_i;
        endcase
    end

endmodule

// File: rtl/acc_logic_stage.sv
// Registered accumulator stage with valid/ready handshake and one-entry result
// buffer; ACC_SAT_EN adds saturating ADD/SUB and the sat flag.
module acc_logic_stage #(
    parameter int WIDTH = 4
) (
    input logic              clk,
    input logic              rst,
    acc_logic_stage_if.slave bus
);
    import acc_pkg::*;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, nxt_acc;
    logic             carry_q, carry_d, nxt_carry;
    logic             ovf_q, ovf_d, nxt_ovf;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic             illegal, accept, pop, take;
`ifdef ACC_SAT_EN
    logic             sat_q, sat_d, nxt_sat;
`endif

    acc_logic_unit #(.WIDTH(WIDTH)) u_unit (
        .opcode_i   (bus.opcode),
        .acc_i      (acc_q),
        .operand_i  (bus.operand),
        .acc_o      (nxt_acc),
        .carry_o    (nxt_carry),
        .overflow_o (nxt_ovf),
`ifdef ACC_SAT_EN
        .sat_o      (nxt_sat),
`endif
        .illegal_o  (illegal)
    );

    assign bus.in_ready  = (state_q == ST_HOLD) ? bus.out_ready : 1'b1;
    assign bus.out_valid = (state_q != ST_IDLE);
    assign accept        = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    // In ERR only a CLR is taken; elsewhere any legal accepted opcode is.
    assign take = accept & ~illegal &
                  ((state_q != ST_ERR) | (bus.opcode == OP_CLR));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        err_d   = err_q;
`ifdef ACC_SAT_EN
        sat_d   = sat_q;
`endif
        if (take) begin
            state_d = ST_HOLD;
            acc_d   = nxt_acc;
            carry_d = nxt_carry;
            ovf_d   = nxt_ovf;
            zero_d  = (nxt_acc == '0);
            err_d   = 1'b0;
`ifdef ACC_SAT_EN
            sat_d   = nxt_sat;
`endif
        end else if (accept && illegal && state_q != ST_ERR) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
        end else if (state_q == ST_HOLD && pop) begin
            state_d = ST_IDLE;
        end else if (state_q != ST_HOLD && state_q != ST_ERR) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
            err_q   <= 1'b0;
`ifdef ACC_SAT_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
`ifdef ACC_SAT_EN
            sat_q   <= sat_d;
`endif
        end
    end

    assign bus.acc      = acc_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = ovf_q;
    assign bus.zero     = zero_q;
    assign bus.error    = err_q;
`ifdef ACC_SAT_EN
    assign bus.sat      = sat_q;
`endif

endmodule
